// File: rtl/prince_pkg.sv
// Shared PRINCE constants, the k0 whitening-key derivation and the key-path FSM state type.
// Used by both the encryption and decryption key paths.
package prince_pkg;

  localparam logic [63:0] PRINCE_ALPHA = 64'hC0AC29B7C97C50DD;

  localparam logic [63:0] PRINCE_RC [0:11] = '{
    64'h0000000000000000, 64'h13198A2E03707344, 64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89, 64'h452821E638D01377, 64'hBE5466CF34E90C6C,
    64'h7EF84F78FD955CB1, 64'h85840851F1AC43AA, 64'hC882D32F25323C54,
    64'h64A51195E0E3610D, 64'hD3B5A399CA0C2399, 64'hC0AC29B7C97C50DD
  };

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StFin    = 2'd2
  } prince_ks_state_e;

  // (k0 >>> 1) ^ (k0 >> 63); linear, so it can be applied to each share on its own.
  function automatic logic [63:0] k0_prime(input logic [63:0] k0);
    return {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
  endfunction

endpackage

// File: rtl/prince_rc_rom.sv
// PRINCE round-constant lookup; indices 12..15 return zero.
module prince_rc_rom
  import prince_pkg::*;
(
  input  logic [3:0]  i_idx,
  output logic [63:0] o_rc
);

  always_comb begin
    o_rc = '0;
    case (i_idx)
      4'd0:    o_rc = PRINCE_RC[0];
      4'd1:    o_rc = PRINCE_RC[1];
      4'd2:    o_rc = PRINCE_RC[2];
      4'd3:    o_rc = PRINCE_RC[3];
      4'd4:    o_rc = PRINCE_RC[4];
      4'd5:    o_rc = PRINCE_RC[5];
      4'd6:    o_rc = PRINCE_RC[6];
      4'd7:    o_rc = PRINCE_RC[7];
      4'd8:    o_rc = PRINCE_RC[8];
      4'd9:    o_rc = PRINCE_RC[9];
      4'd10:   o_rc = PRINCE_RC[10];
      4'd11:   o_rc = PRINCE_RC[11];
      default: o_rc = '0;
    endcase
  end

endmodule

// File: rtl/prince_dec_key_sched.sv
// Two-share PRINCE decryption round-key sequencer: streams k0', k1^alpha^RC[0..11], k0
// over valid/ready, keeping share 0 and share 1 datapaths strictly separate.
module prince_dec_key_sched
  import prince_pkg::*;
#(
  parameter logic [63:0] ALPHA = PRINCE_ALPHA
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_s0,
  input  logic [127:0] key_s1,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [63:0]  rk_s0,
  output logic [63:0]  rk_s1,
  output logic [3:0]   rk_idx
);

  prince_ks_state_e r_state;
  logic [127:0]     r_key_s0;
  logic [127:0]     r_key_s1;
  logic [63:0]      r_rk_s0;
  logic [63:0]      r_rk_s1;
  logic [3:0]       r_idx;
  logic             r_valid;

  logic             w_xfer;
  logic             w_last;
  logic [63:0]      w_rc;
  logic [63:0]      w_nxt_s0;
  logic [63:0]      w_nxt_s1;

  // Next key is idx+1, whose constant is RC[idx]; so the ROM is addressed by the current index.
  prince_rc_rom u_rc_rom (
    .i_idx (r_idx),
    .o_rc  (w_rc)
  );

  assign w_xfer = r_valid & rk_ready;
  assign w_last = (r_idx == 4'd13);

  // Constants only ever touch share 0; the index used for selection is public.
  assign w_nxt_s0 = (r_idx == 4'd12) ? r_key_s0[127:64] : (r_key_s0[63:0] ^ ALPHA ^ w_rc);
  assign w_nxt_s1 = (r_idx == 4'd12) ? r_key_s1[127:64] : r_key_s1[63:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_key_s0 <= '0;
      r_key_s1 <= '0;
      r_rk_s0  <= '0;
      r_rk_s1  <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_key_s0 <= key_s0;
            r_key_s1 <= key_s1;
            r_rk_s0  <= k0_prime(key_s0[127:64]);
            r_rk_s1  <= k0_prime(key_s1[127:64]);
            r_idx    <= 4'd0;
            r_valid  <= 1'b1;
            r_state  <= StStream;
          end
        end
        StStream: begin
          if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_idx   <= 4'd0;
              r_rk_s0 <= '0;
              r_rk_s1 <= '0;
              r_state <= StFin;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_rk_s0 <= w_nxt_s0;
              r_rk_s1 <= w_nxt_s1;
            end
          end
        end
        StFin:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = (r_state == StStream);
  assign done     = (r_state == StFin);
  assign rk_valid = r_valid;
  assign rk_s0    = r_rk_s0;
  assign rk_s1    = r_rk_s1;
  assign rk_idx   = r_idx;

endmodule

// File: tb/tb_prince_dec_key_sched.sv
// Scoreboard bench for prince_dec_key_sched: stimulus queues expected keys, a negedge monitor
// pops and compares on every handshake.
module tb_prince_dec_key_sched;

  localparam logic [63:0] ALPHA = 64'hC0AC29B7C97C50DD;

  typedef struct {
    logic [3:0]  idx;
    logic [63:0] sum;
    logic [63:0] s1;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_s0 = '0;
  logic [127:0] key_s1 = '0;
  logic         busy, done, rk_valid;
  logic         rk_ready = 1'b1;
  logic [63:0]  rk_s0, rk_s1;
  logic [3:0]   rk_idx;

  exp_t         exp_q[$];
  int           n_pass = 0;
  int           n_tot = 0;
  logic [63:0]  cap_sum [14];
  logic [63:0]  cap_s1 [14];
  logic [63:0]  ref_sum [14];

  prince_dec_key_sched #(.ALPHA(ALPHA)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_s0   (key_s0),
    .key_s1   (key_s1),
    .busy     (busy),
    .done     (done),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_s0    (rk_s0),
    .rk_s1    (rk_s1),
    .rk_idx   (rk_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic logic [63:0] rc(input int i);
    case (i)
      0:       return 64'h0000000000000000;
      1:       return 64'h13198A2E03707344;
      2:       return 64'hA4093822299F31D0;
      3:       return 64'h082EFA98EC4E6C89;
      4:       return 64'h452821E638D01377;
      5:       return 64'hBE5466CF34E90C6C;
      6:       return 64'h7EF84F78FD955CB1;
      7:       return 64'h85840851F1AC43AA;
      8:       return 64'hC882D32F25323C54;
      9:       return 64'h64A51195E0E3610D;
      10:      return 64'hD3B5A399CA0C2399;
      default: return 64'hC0AC29B7C97C50DD;
    endcase
  endfunction

  function automatic logic [63:0] kp(input logic [63:0] k);
    return {k[0], k[63:1]} ^ {63'd0, k[63]};
  endfunction

  function automatic logic [63:0] gold(input logic [127:0] key, input int i);
    if (i == 0) return kp(key[127:64]);
    if (i == 13) return key[127:64];
    return key[63:0] ^ ALPHA ^ rc(i - 1);
  endfunction

  function automatic logic [63:0] share1(input logic [127:0] mask, input int i);
    if (i == 0) return kp(mask[127:64]);
    if (i == 13) return mask[127:64];
    return mask[63:0];
  endfunction

  // Monitor: a transfer happens at the next posedge when valid & ready are seen here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rk_valid && rk_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("unexpected_key", {60'd0, rk_idx}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rk_idx", {60'd0, rk_idx}, {60'd0, e.idx});
          check("rk_s1", rk_s1, e.s1);
          check("share_sum", rk_s0 ^ rk_s1, e.sum);
          if (rk_idx < 4'd14) begin
            cap_sum[rk_idx] = rk_s0 ^ rk_s1;
            cap_s1[rk_idx]  = rk_s1;
          end
        end
      end
    end
  end

  task automatic run(input logic [127:0] key, input logic [127:0] mask, input int bp_at,
                     input int ign_at, input int rst_at);
    int          n;
    bit          got;
    bit          bp_done;
    logic [3:0]  h_idx;
    logic [63:0] h0, h1;
    for (int i = 0; i < 14; i++) exp_q.push_back('{idx: 4'(i), sum: gold(key, i),
                                                   s1: share1(mask, i)});
    key_s0 = key ^ mask;
    key_s1 = mask;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_s0 = {$urandom, $urandom, $urandom, $urandom};
    key_s1 = {$urandom, $urandom, $urandom, $urandom};
    check("lat1_valid", {63'd0, rk_valid}, 64'd1);
    check("lat1_busy", {63'd0, busy}, 64'd1);
    check("lat1_idx", {60'd0, rk_idx}, 64'd0);
    n = 0;
    got = 1'b0;
    bp_done = 1'b0;
    while (!got && n < 40) begin
      if (rst_at >= 0 && rk_valid && rk_idx == 4'(rst_at)) begin
        rst = 1'b1;
        #1;
        check("rst_valid", {63'd0, rk_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_idx", {60'd0, rk_idx}, 64'd0);
        check("rst_s0", rk_s0, 64'd0);
        check("rst_s1", rk_s1, 64'd0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (bp_at >= 0 && !bp_done && rk_valid && rk_idx == 4'(bp_at)) begin
        h_idx = rk_idx;
        h0 = rk_s0;
        h1 = rk_s1;
        rk_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          n++;
          check("bp_valid", {63'd0, rk_valid}, 64'd1);
          check("bp_idx", {60'd0, rk_idx}, {60'd0, h_idx});
          check("bp_s0", rk_s0, h0);
          check("bp_s1", rk_s1, h1);
        end
        rk_ready = 1'b1;
        bp_done = 1'b1;
      end
      if (ign_at >= 0 && rk_valid && rk_idx == 4'(ign_at)) start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) got = 1'b1;
    end
    check("done_seen", {63'd0, got}, 64'd1);
    check("done_cycle", 64'(n), (bp_at >= 0) ? 64'd17 : 64'd14);
    check("fin_valid", {63'd0, rk_valid}, 64'd0);
    check("fin_busy", {63'd0, busy}, 64'd0);
    check("keys_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    // start during the done cycle must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_fin_busy", {63'd0, busy}, 64'd0);
    check("done_pulse_len", {63'd0, done}, 64'd0);
  endtask

  initial begin
    #40_000_000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] mask, key;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_valid", {63'd0, rk_valid}, 64'd0);
    check("reset_idx", {60'd0, rk_idx}, 64'd0);
    check("reset_s0", rk_s0, 64'd0);
    check("reset_s1", rk_s1, 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;

    // All-zero key and masks
    run('0, '0, -1, -1, -1);
    check("zero_idx0", cap_sum[0], 64'h0);
    check("zero_idx1", cap_sum[1], 64'hC0AC29B7C97C50DD);
    check("zero_idx12", cap_sum[12], 64'h0);
    check("zero_idx13", cap_sum[13], 64'h0);

    // All-ones key under a random mask
    mask = {$urandom, $urandom, $urandom, $urandom};
    run({128{1'b1}}, mask, -1, -1, -1);
    check("ones_idx0", cap_sum[0], 64'hFFFFFFFFFFFFFFFE);
    check("ones_idx13", cap_sum[13], 64'hFFFFFFFFFFFFFFFF);
    check("ones_idx2", cap_sum[2], 64'h2C4A5C6635F3DC66);
    for (int i = 1; i <= 12; i++) check("ones_s1_mask", cap_s1[i], mask[63:0]);

    // Backpressure at idx 5
    run(128'h0123456789ABCDEF_FEDCBA9876543210, {$urandom, $urandom, $urandom, $urandom},
        5, -1, -1);

    // start with another key at idx 7 is ignored
    run(128'h00112233445566778899AABBCCDDEEFF, {$urandom, $urandom, $urandom, $urandom},
        -1, 7, -1);

    // Reset mid-stream, then a fresh stream
    run(128'hDEADBEEFCAFEF00D_0BADF00DFEEDFACE, {$urandom, $urandom, $urandom, $urandom},
        -1, -1, 9);
    @(posedge clk); #1;
    run(128'h5555AAAA5555AAAA_3333CCCC3333CCCC, {$urandom, $urandom, $urandom, $urandom},
        -1, -1, -1);

    // Fixed key, varying masks: share sums must not change
    key = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    run(key, {$urandom, $urandom, $urandom, $urandom}, -1, -1, -1);
    for (int i = 0; i < 14; i++) ref_sum[i] = cap_sum[i];
    repeat (3) begin
      run(key, {$urandom, $urandom, $urandom, $urandom}, -1, -1, -1);
      for (int i = 0; i < 14; i++) check("mask_invariance", cap_sum[i], ref_sum[i]);
    end

    // Random keys and masks against the golden schedule
    for (int r = 0; r < 1000; r++) begin
      run({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/prince_dec_key_sched.md
# prince_dec_key_sched

Masked (first-order, two-share) round-key sequencer for the PRINCE decryption datapath. It latches a shared 128-bit key and streams the 14 decryption round keys over a valid/ready interface, one per accepted handshake: input whitening k0′, core keys (k1 ⊕ α ⊕ RC_i) for i = 0..11, then output whitening k0. Each key is emitted as two 64-bit shares. The block feeds the per-bit key-addition stage of the decryption round, mirroring the key path on the encryption side. All key material stays share-separated; constants are applied to share 0 only.

## Interface
Parameters:
- ALPHA, 64'hC0AC29B7C97C50DD, PRINCE reflection constant applied to k1.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a new key stream; sampled only in IDLE.
- key_s0  in  128  key share 0, {k0, k1}; k0 = [127:64].
- key_s1  in  128  key share 1; key = key_s0 ⊕ key_s1.
- busy  out  1  high while a stream is in progress.
- done  out  1  one-cycle pulse after the last key is accepted.
- rk_valid  out  1  round-key output valid.
- rk_ready  in  1  consumer accepts the current round key.
- rk_s0  out  64  round-key share 0.
- rk_s1  out  64  round-key share 1.
- rk_idx  out  4  index of the current round key, 0..13.

## Operation
- FSM states:
  - IDLE → STREAM on start.
  - STREAM → FIN on the handshake at rk_idx = 13.
  - FIN → IDLE unconditionally.
- On start in IDLE, latch key_s0 and key_s1 into share registers. Inputs are don't-care afterwards.
- k0′ = (k0 >>> 1) ⊕ (k0 >> 63), computed per share. The map is linear, so no share mixing.
- Key sequence, where each share j uses k0_j, k0′_j, k1_j:
  - idx 0: s0 = k0′_0, s1 = k0′_1.
  - idx 1..12: s0 = k1_0 ⊕ ALPHA ⊕ RC[idx−1], s1 = k1_1.
  - idx 13: s0 = k0_0, s1 = k0_1.
- RC[0..11] are the standard PRINCE round constants (RC0 = 0, RC11 = C0AC29B7C97C50DD).
- rk_s0, rk_s1, rk_valid and rk_idx are registered outputs. No combinational path from inputs to outputs.
- Handshake:
  - The round key transfers when rk_valid and rk_ready are both high.
  - While rk_valid is high and rk_ready is low, rk_s0, rk_s1 and rk_idx hold stable.
  - rk_valid never drops without a transfer.
- start while busy or in FIN is ignored; the latched key is not overwritten.
- Share 1 outputs must never depend on share 0 registers, and vice versa.

## Timing
- Reset values: busy = 0, done = 0, rk_valid = 0, rk_idx = 0, rk_s0 = 0, rk_s1 = 0. Key registers clear to 0. FSM goes to IDLE.
- start high at edge T (IDLE):
  - busy = 1 and rk_valid = 1 with rk_idx = 0 from T+1.
- With rk_ready held high, keys idx 0..13 are presented in cycles T+1..T+14, one per cycle, with no bubbles.
- After the handshake at idx 13 (edge E):
  - rk_valid = 0 and busy = 0 from E+1.
  - done = 1 for exactly one cycle at E+1 (the FIN state).
- Back-to-back: start asserted during the done cycle is ignored. The earliest accepted start is the cycle after done.
- Throughput: 14 keys in 14 cycles plus 1 cycle start latency plus 1 FIN cycle.
- rst asserted mid-stream: outputs take reset values immediately (asynchronously). The stream is abandoned; no done pulse.

## Structure
- Shared package prince_pkg:
  - PRINCE_ALPHA.
  - PRINCE_RC array [0:11] of 64-bit constants.
  - Function k0_prime(64-bit) → 64-bit.
  - FSM state enum. Also used by the encryption key path.
- One sub-module, prince_rc_rom: combinational 4-bit index → 64-bit RC lookup. Shared with the encryption round counter.
- Top level holds the FSM, share registers, index counter and output registers.

## Test plan
- Key = 0, both shares 0, rk_ready = 1:
  - idx 0 = 0.
  - idx 1 = C0AC29B7C97C50DD.
  - idx 12 = 0 (ALPHA ⊕ RC11).
  - idx 13 = 0.
  - done at T+15.
- Key = all ones, key_s1 = random mask, key_s0 = key ⊕ mask:
  - rk_s0 ⊕ rk_s1 at idx 0 = FFFFFFFFFFFFFFFE.
  - at idx 13 = FFFFFFFFFFFFFFFF.
  - at idx 2 = FFFF…FF ⊕ ALPHA ⊕ 13198A2E03707344.
  - rk_s1 at idx 1..12 = mask[63:0].
- Backpressure: drop rk_ready for 3 cycles while rk_idx = 5 → rk_idx, rk_s0 and rk_s1 hold stable and rk_valid stays high; the stream resumes at idx 6 with no key skipped or duplicated.
- start pulsed at idx 7 with a different key → ignored; remaining keys come from the original key; 14 keys total.
- rst asserted at idx 9 → all outputs 0 in the same cycle. A new start after release produces idx 0 of the new key at latency 1.
- Random keys and masks (≥ 1000 runs) → the unmasked sequence matches the golden PRINCE decryption key schedule. Varying the mask with a fixed key leaves share-sum outputs unchanged.
